rx_lane_deskew: RTL

RX_LANE_DESKEW -- requirements
Module: rx_lane_deskew

---
 rtl/rx_deskew_pkg.sv | 14 +
 rtl/rx_deskew_fifo.sv | 58 +++++
 rtl/rx_lane_deskew.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rx_deskew_pkg.sv
// Shared types and constants for the RX lane deskew block.
// Symbol width, alignment marker default and FSM states.
package rx_deskew_pkg;

  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] MARKER_DEF = 8'hBC;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_LOCKED
  } state_e;

endpackage

// File: rtl/rx_deskew_fifo.sv
// Per-lane synchronous FIFO with flush; head is the oldest entry.
// Flush beats push/pop; a push into a full FIFO without a pop is dropped.
module rx_deskew_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/rx_lane_deskew.sv
// Multi-lane deskew: buffers each lane, aligns on a K-marker column,
// then emits aligned columns and watches for loss of alignment.
module rx_lane_deskew
  import rx_deskew_pkg::*;
#(
  parameter int          NUM_LANES = 16,
  parameter int          DEPTH     = 8,
  parameter int          MAX_SKEW  = 4,
  parameter logic [7:0]  MARKER    = MARKER_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [4:0]                 activeLanes,
  input  logic [NUM_LANES*8-1:0]     inData,
  input  logic [NUM_LANES-1:0]       inDataK,
  input  logic [NUM_LANES-1:0]       inValid,
  output logic [NUM_LANES*8-1:0]     outData,
  output logic [NUM_LANES-1:0]       outDataK,
  output logic                       outValid,
  output logic                       deskewLocked,
  output logic                       skewError,
  output logic [$clog2(DEPTH):0]     measuredSkew
);

  localparam int SW = $clog2(DEPTH) + 1;
  localparam int EW = SYM_W + 1;
  localparam logic [SW-1:0] SKEW_LIM = SW'(MAX_SKEW);

  state_e state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] meas_q, meas_d;
  logic [NUM_LANES*8-1:0] odata_q, odata_d;
  logic [NUM_LANES-1:0] ok_q, ok_d;
  logic oval_q, oval_d;
  logic err_q, err_d;
  logic [4:0] lanes_q;

  logic [EW-1:0] head [NUM_LANES];
  logic [NUM_LANES-1:0] full, empty;
  logic [NUM_LANES-1:0] push, pop;
  logic [NUM_LANES-1:0] act, mk;
  logic [NUM_LANES*8-1:0] col_data;
  logic [NUM_LANES-1:0] col_k;
  logic flush_all;
  logic all_mk, any_mk, all_ne, ovf;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rx_deskew_fifo #(
      .WIDTH(EW),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush_all | ~act[g]),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   ({inDataK[g], inData[g*SYM_W +: SYM_W]}),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Per-lane status and the column that would leave on a pop.
  always_comb begin
    act      = '0;
    mk       = '0;
    col_data = '0;
    col_k    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      act[i] = int'(activeLanes) > i;
      mk[i]  = act[i] && !empty[i] &&
               (head[i] == {1'b1, MARKER});
      if (act[i]) begin
        col_data[i*SYM_W +: SYM_W] = head[i][SYM_W-1:0];
        col_k[i] = head[i][SYM_W];
      end
    end
    all_mk = (mk == act) && (|act);
    any_mk = |mk;
    all_ne = ((~empty & act) == act);
  end

  always_comb begin
    pop = '0;
    if (state_q == ST_SEARCH) begin
      pop = all_mk ? act : (act & ~empty & ~mk);
    end else if (state_q == ST_LOCKED) begin
      pop = all_ne ? act : '0;
    end
    push = act & inValid;
    ovf  = |(push & full & ~pop);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    meas_d    = meas_q;
    odata_d   = odata_q;
    ok_d      = ok_q;
    oval_d    = 1'b0;
    err_d     = 1'b0;
    flush_all = 1'b0;
    if (!enable || activeLanes == 5'd0) begin
      state_d   = ST_IDLE;
      flush_all = 1'b1;
      cnt_d     = '0;
      odata_d   = '0;
      ok_d      = '0;
    end else if (state_q == ST_IDLE) begin
      state_d   = ST_SEARCH;
      flush_all = 1'b1;
    end else if (activeLanes != lanes_q) begin
      state_d   = ST_SEARCH;
      flush_all = 1'b1;
      cnt_d     = '0;
    end else if (ovf) begin
      state_d   = ST_SEARCH;
      err_d     = 1'b1;
      flush_all = 1'b1;
      cnt_d     = '0;
    end else if (state_q == ST_SEARCH) begin
      if (all_mk) begin
        state_d = ST_LOCKED;
        oval_d  = 1'b1;
        meas_d  = cnt_q;
        odata_d = col_data;
        ok_d    = col_k;
        cnt_d   = '0;
      end else if (any_mk) begin
        // Counter sits at 0 on the first marker cycle.
        if (cnt_q >= SKEW_LIM) begin
          err_d     = 1'b1;
          flush_all = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + SW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end else if (all_ne) begin
      if (any_mk && !all_mk) begin
        state_d   = ST_SEARCH;
        err_d     = 1'b1;
        flush_all = 1'b1;
      end else begin
        oval_d  = 1'b1;
        odata_d = col_data;
        ok_d    = col_k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      meas_q  <= '0;
      odata_q <= '0;
      ok_q    <= '0;
      oval_q  <= 1'b0;
      err_q   <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      meas_q  <= meas_d;
      odata_q <= odata_d;
      ok_q    <= ok_d;
      oval_q  <= oval_d;
      err_q   <= err_d;
      lanes_q <= activeLanes;
    end
  end

  assign outData      = odata_q;
  assign outDataK     = ok_q;
  assign outValid     = oval_q;
  assign skewError    = err_q;
  assign deskewLocked = (state_q == ST_LOCKED);
  assign measuredSkew = meas_q;

endmodule
